counter_bank: RTL

Parametrised bank of 2^BIT_ADDR counter registers, each BIT_DATO bits wide. It has two combinational read ports and one update port that can increment, decrement or load the addressed entry, with wrap or saturate selected by parameter. A sequential clear engine sweeps the bank back to RST_VAL one entry per cycle. It replaces the single-port increment-only register bank in the pattern/VGA datapath and feeds per-cell state to the display logic.

---
 rtl/counter_bank.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
//
// Bank of NREG = 2^BIT_ADDR counters, each BIT_DATO bits wide. It has two
// combinational read ports and one update port. The update port can do
// increment, decrement or load on the addressed entry. Inc/dec either wraps or
// saturates, as chosen by SATURATE. A clear engine sweeps the bank back to
// RST_VAL, one entry per clock.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   addrR0    in   read port 0 address
//   addrR1    in   read port 1 address
//   addrW     in   update address
//   op        in   00 none, 01 inc, 10 dec, 11 load datIn
//   datIn     in   load data
//   clr       in   start a clear sweep (level, honoured only when idle)
//   datOutR0  out  breg[addrR0], combinational
//   datOutR1  out  breg[addrR1], combinational
//   busy      out  high while the clear sweep runs
//   done      out  one-cycle pulse after the last sweep write
//   ovf       out  registered one-cycle flag: inc at max or dec at zero
// -----------------------------------------------------------------------------
module counter_bank #(
    parameter int BIT_ADDR = 4,
    parameter int BIT_DATO = 3,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIT_ADDR-1:0] addrR0,
    input  logic [BIT_ADDR-1:0] addrR1,
    input  logic [BIT_ADDR-1:0] addrW,
    input  logic [1:0]          op,
    input  logic [BIT_DATO-1:0] datIn,
    input  logic                clr,
    output logic [BIT_DATO-1:0] datOutR0,
    output logic [BIT_DATO-1:0] datOutR1,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int NREG = 1 << BIT_ADDR;

    localparam logic [BIT_DATO-1:0] RST_D    = RST_VAL[BIT_DATO-1:0];
    localparam logic [BIT_DATO-1:0] DAT_MAX  = '1;
    localparam logic [BIT_DATO-1:0] DAT_ONE  = 1;
    localparam logic [BIT_ADDR-1:0] PTR_LAST = '1;
    localparam logic [BIT_ADDR-1:0] PTR_ONE  = 1;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state, state_nxt;
    logic [BIT_DATO-1:0] breg [NREG];
    logic [BIT_ADDR-1:0] ptr;

    logic [BIT_DATO-1:0] cur;
    logic [BIT_DATO-1:0] upd_val;
    logic                upd_en;
    logic                bound;

    // Read ports are plain muxes over the array.
    assign datOutR0 = breg[addrR0];
    assign datOutR1 = breg[addrR1];
    assign busy     = (state == CLEAR);

    // Update datapath. The boundary is found by an explicit compare against
    // max/zero, not by a carry out of the adder.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that leaves a combinational output unassigned would infer a latch.
        cur     = breg[addrW];
        upd_val = cur;
        upd_en  = 1'b0;
        bound   = 1'b0;
        unique case (op)
            OP_INC: begin
                upd_en = 1'b1;
                if (cur == DAT_MAX) begin
                    bound   = 1'b1;
                    upd_val = (SATURATE != 0) ? cur : '0;
                end else begin
                    upd_val = cur + DAT_ONE;
                end
            end
            OP_DEC: begin
                upd_en = 1'b1;
                if (cur == '0) begin
                    bound   = 1'b1;
                    upd_val = (SATURATE != 0) ? cur : DAT_MAX;
                end else begin
                    upd_val = cur - DAT_ONE;
                end
            end
            OP_LOAD: begin
                upd_en  = 1'b1;
                upd_val = datIn;
            end
            OP_NONE: ;
            default: ;
        endcase
    end

    // Next-state logic of the sweep FSM. The terminal pointer value is
    // detected before the pointer wraps back to zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clr) state_nxt = CLEAR;
            CLEAR:   if (ptr == PTR_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, counter array, sweep pointer and the flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array sits in flops, not in a RAM macro, because the
            // design needs every entry at RST_VAL as soon as reset asserts.
            for (int i = 0; i < NREG; i++) begin
                breg[i] <= RST_D;
            end
            state <= IDLE;
            ptr   <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every register here
            // samples the values from before the edge, so an op and a sweep
            // start in the same cycle do not race.
            state <= state_nxt;
            done  <= 1'b0;
            ovf   <= 1'b0;
            unique case (state)
                IDLE: begin
                    // An op in the same cycle as clr still executes. The
                    // sweep overwrites that entry later.
                    if (upd_en) begin
                        breg[addrW] <= upd_val;
                    end
                    ovf <= bound;
                    ptr <= '0;
                end
                CLEAR: begin
                    breg[ptr] <= RST_D;
                    ptr       <= ptr + PTR_ONE;
                    if (ptr == PTR_LAST) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
